if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined core, directly upstream of instruction decode. It owns the program counter and issues fetches to instruction memory over a variable-latency req/ack handshake. It absorbs decode-side freezes with a one-entry skid buffer and handles branch redirects, including redirects that arrive while a fetch is outstanding. Its registered outputs form the IF/ID pipeline register that decode consumes.

## Interface
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall from decode: hold IF/ID contents
- branch_taken  in  1  redirect request from execute: flush and jump
- branch_addr  in  ADDR_W  redirect target, sampled when branch_taken=1
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  memory response valid; may assert in the same cycle as the request
- imem_rdata  in  DATA_W  instruction, valid when imem_ack=1
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  DATA_W  fetched instruction
- ifid_pc  out  ADDR_W  address of the fetched instruction + 4

## Operation
- **States:** FETCH (request outstanding), HOLD (an instruction is parked in the skid buffer and req=0), DRAIN (a stale request is outstanding after a redirect).
- **Request signals:** imem_req=1 in FETCH and DRAIN, 0 in HOLD. It is forced to 0 while rst_n=0. imem_addr=pc in FETCH; in DRAIN it holds the stale address until ack.
- **FETCH, ack=1, freeze=0:** IF/ID loads {valid=1, imem_rdata, pc+4}, pc<=pc+4, stay in FETCH.
- **FETCH, ack=1, freeze=1:** buffer<=imem_rdata, bufpc<=pc+4, pc<=pc+4, go to HOLD. IF/ID is unchanged.
- **FETCH, ack=0:** no state change. If freeze=0, IF/ID loads valid=0 (a bubble). If freeze=1, IF/ID holds.
- **HOLD, freeze=0:** IF/ID loads {1, buffer, bufpc}, go to FETCH.
- **HOLD, freeze=1:** stay in HOLD.
- **branch_taken=1 (highest priority, overrides freeze in every state):**
  - IF/ID is flushed to {0, 0, 0} and pc<=branch_addr.
  - Any buffer content is discarded.
  - If in FETCH with ack=0, or already in DRAIN with ack=0, go to DRAIN.
  - Otherwise (including ack in the same cycle, whose data is discarded), go to FETCH.
- **DRAIN:**
  - With ack=1, the data is discarded and the state goes to FETCH. pc was already loaded with the target on the redirect cycle.
  - With ack=0, stay in DRAIN.
  - IF/ID loads a bubble unless freeze=1.
- **Address arithmetic:** pc+4 is modulo 2^ADDR_W, so 0xFFFFFFFC+4 = 0.
- **pc reporting:** pc is internal. ifid_pc always reports the fetched address + 4.

## Timing
- **Reset values (asynchronous):** pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc=0, buffer=0. imem_req=0 while reset is asserted; imem_req=1 with imem_addr=RESET_PC in the first cycle after rst_n rises.
- **Latency:** with zero-wait memory (ack in the same cycle as req), one instruction per cycle, and IF/ID updates on the edge that ends the ack cycle.
- **Freeze:** IF/ID stays bit-identical for every cycle that freeze=1 and branch_taken=0.
- **Freeze release:** the parked instruction appears on IF/ID at the first edge with freeze=0. The next request issues in the following cycle.
- **Handshake rule:** once imem_req rises, the address does not change until the ack edge, even across a redirect (DRAIN).
- **Redirect timing:** no instruction fetched before a redirect ever reaches ifid_valid=1 after it. The first fetch at branch_addr issues in the cycle after the redirect (FETCH path) or the cycle after the drain ack (DRAIN path).

## Test plan
- **Reset:** hold rst_n=0, then release with zero-wait memory returning instr=addr^0xA5A5A5A5 → addresses 0, 4, 8 are requested on consecutive cycles; IF/ID shows pc 4, 8, 12 with the matching instructions and valid=1.
- **Freeze:** assert freeze for 3 cycles while fetching at 0x10 → IF/ID holds the 0x0C instruction; the 0x10 instruction is parked and imem_req=0 in HOLD. After release, IF/ID={1, instr@0x10, 0x14}, and the next request is 0x14.
- **Slow memory:** ack arrives 3 cycles after request at 0x20 → imem_addr stays 0x20 throughout, IF/ID shows 3 bubbles (valid=0), then {1, instr@0x20, 0x24}.
- **Redirect during outstanding fetch:** branch_taken with branch_addr=0x100 while 0x20 is pending → IF/ID is flushed, DRAIN keeps addr=0x20 until ack, the 0x20 data is dropped, the next request is 0x100, and IF/ID then shows pc 0x104.
- **Simultaneous events:**
  - branch_taken and freeze asserted together in HOLD → buffer discarded, IF/ID valid=0, fetch at target.
  - branch_taken together with ack → ack data dropped, no DRAIN entered.
- **Wrap and mid-operation reset:**
  - RESET_PC=0xFFFFFFFC → second request is 0x0.
  - Assert rst_n=0 during DRAIN → immediate return to reset values, imem_req=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches, parks one
// instruction across decode freezes and drains stale requests after redirects.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] stale_addr_r, stale_addr_s;
  logic [ADDR_W-1:0] buf_pc_r, buf_pc_s;
  logic [DATA_W-1:0] buf_instr_r, buf_instr_s;
  logic              ifid_valid_r, ifid_valid_s;
  logic [DATA_W-1:0] ifid_instr_r, ifid_instr_s;
  logic [ADDR_W-1:0] ifid_pc_r, ifid_pc_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign pc_inc_s = pc_r + ADDR_W'(32'd4);

  // A drained request keeps presenting its original address until acked.
  assign imem_req   = rst_n & (state_r != S_HOLD);
  assign imem_addr  = (state_r == S_DRAIN) ? stale_addr_r : pc_r;
  assign ifid_valid = ifid_valid_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc    = ifid_pc_r;

  // Next-state and IF/ID update logic; redirect outranks every other event.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    stale_addr_s = stale_addr_r;
    buf_pc_s     = buf_pc_r;
    buf_instr_s  = buf_instr_r;
    ifid_valid_s = ifid_valid_r;
    ifid_instr_s = ifid_instr_r;
    ifid_pc_s    = ifid_pc_r;

    if (branch_taken) begin
      ifid_valid_s = 1'b0;
      ifid_instr_s = '0;
      ifid_pc_s    = '0;
      pc_s         = branch_addr;
      buf_instr_s  = '0;
      buf_pc_s     = '0;
      if (!imem_ack && (state_r != S_HOLD)) begin
        state_s = S_DRAIN;
      end else begin
        state_s = S_FETCH;
      end
      // Re-redirecting while draining must keep the original stale address.
      if (state_r == S_FETCH) begin
        stale_addr_s = pc_r;
      end else begin
        stale_addr_s = stale_addr_r;
      end
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_ack) begin
            pc_s = pc_inc_s;
            if (freeze) begin
              buf_instr_s = imem_rdata;
              buf_pc_s    = pc_inc_s;
              state_s     = S_HOLD;
            end else begin
              ifid_valid_s = 1'b1;
              ifid_instr_s = imem_rdata;
              ifid_pc_s    = pc_inc_s;
            end
          end else if (!freeze) begin
            ifid_valid_s = 1'b0;
          end else begin
            ifid_valid_s = ifid_valid_r;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            ifid_valid_s = 1'b1;
            ifid_instr_s = buf_instr_r;
            ifid_pc_s    = buf_pc_r;
            state_s      = S_FETCH;
          end else begin
            state_s = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            state_s = S_FETCH;
          end else begin
            state_s = S_DRAIN;
          end
          if (!freeze) begin
            ifid_valid_s = 1'b0;
          end else begin
            ifid_valid_s = ifid_valid_r;
          end
        end
        default: begin
          state_s = S_FETCH;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_PC;
      stale_addr_r <= '0;
      buf_pc_r     <= '0;
      buf_instr_r  <= '0;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= '0;
      ifid_pc_r    <= '0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      stale_addr_r <= stale_addr_s;
      buf_pc_r     <= buf_pc_s;
      buf_instr_r  <= buf_instr_s;
      ifid_valid_r <= ifid_valid_s;
      ifid_instr_r <= ifid_instr_s;
      ifid_pc_r    <= ifid_pc_s;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected handshakes and IF/ID contents are
// queued by the stimulus and checked by an independent monitor.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        ack_en = 1'b0;
  logic        imem_req, imem_ack, ifid_valid;
  logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc;
  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_ifid_q[$];

  always #5 clk = ~clk;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ KEY;
  assign w_ack      = w_req;
  assign w_rdata    = w_addr ^ KEY;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc)
  );

  if_stage #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .ifid_valid(w_valid),
    .ifid_instr(w_instr), .ifid_pc(w_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic go(input logic frz, input logic br, input logic ack, input logic [31:0] ba);
    @(posedge clk);
    #1;
    freeze       = frz;
    branch_taken = br;
    ack_en       = ack;
    branch_addr  = ba;
    @(negedge clk);
  endtask

  function automatic logic [63:0] tup(input logic [31:0] fetched);
    return {fetched ^ KEY, fetched + 32'd4};
  endfunction

  // Monitor: every accepted handshake and every newly presented IF/ID entry.
  initial begin : monitor
    logic        prev_valid;
    logic [63:0] prev_tuple;
    logic [63:0] cur;
    prev_valid = 1'b0;
    prev_tuple = 64'h0;
    forever begin
      @(negedge clk);
      cur = {ifid_instr, ifid_pc};
      if (rst_n) begin
        if (imem_req && imem_ack) begin
          if (exp_req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got addr %h expected no handshake", imem_addr);
          end else begin
            chk("req_addr", {32'h0, imem_addr}, {32'h0, exp_req_q.pop_front()});
          end
        end
        if (ifid_valid && (!prev_valid || cur != prev_tuple)) begin
          if (exp_ifid_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ifid_unexpected: got %h expected no valid entry", cur);
          end else begin
            chk("ifid_entry", cur, exp_ifid_q.pop_front());
          end
        end
        prev_valid = ifid_valid;
        prev_tuple = cur;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, ifid_valid}, 64'h0);
    chk("rst_ifid", {ifid_instr, ifid_pc}, 64'h0);
    chk("rst_wrap_req", {63'h0, w_req}, 64'h0);

    // Zero-wait streaming from RESET_PC
    foreach (exp_req_q[i]) ; // no-op
    exp_req_q.push_back(32'h0);  exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);  exp_req_q.push_back(32'hC);
    exp_req_q.push_back(32'h10);
    exp_ifid_q.push_back(tup(32'h0)); exp_ifid_q.push_back(tup(32'h4));
    exp_ifid_q.push_back(tup(32'h8)); exp_ifid_q.push_back(tup(32'hC));
    @(posedge clk); #1;
    rst_n = 1'b1; ack_en = 1'b1;
    @(negedge clk);                                   // c0
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", {32'h0, imem_addr}, 64'h0);
    chk("wrap_first_addr", {32'h0, w_addr}, {32'h0, 32'hFFFFFFFC});
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c1
    chk("addr_c1", {32'h0, imem_addr}, 64'h4);
    chk("wrap_second_addr", {32'h0, w_addr}, 64'h0);
    chk("wrap_ifid", {31'h0, w_valid, w_pc}, {31'h0, 1'b1, 32'h0});
    chk("wrap_instr", {32'h0, w_instr}, {32'h0, 32'hFFFFFFFC ^ KEY});
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c2
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c3
    chk("addr_c3", {32'h0, imem_addr}, 64'hC);

    // Freeze for three cycles while 0x10 is fetched
    exp_ifid_q.push_back(tup(32'h10));
    exp_req_q.push_back(32'h14); exp_req_q.push_back(32'h18); exp_req_q.push_back(32'h1C);
    exp_ifid_q.push_back(tup(32'h14)); exp_ifid_q.push_back(tup(32'h18));
    exp_ifid_q.push_back(tup(32'h1C));
    go(1'b1, 1'b0, 1'b1, 32'h0);                      // c4
    chk("frz_addr", {32'h0, imem_addr}, 64'h10);
    for (int i = 0; i < 3; i++) begin                 // c5..c7
      go((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1, 32'h0);
      chk("hold_req", {63'h0, imem_req}, 64'h0);
      chk("hold_ifid", {ifid_instr, ifid_pc}, tup(32'hC));
      chk("hold_valid", {63'h0, ifid_valid}, 64'h1);
    end
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c8
    chk("release_ifid", {ifid_instr, ifid_pc}, tup(32'h10));
    chk("release_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h14});
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c9
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c10

    // Slow memory at 0x20: three wait cycles
    exp_req_q.push_back(32'h20);
    exp_ifid_q.push_back(tup(32'h20));
    go(1'b0, 1'b0, 1'b0, 32'h0);                      // c11
    chk("slow_addr0", {32'h0, imem_addr}, 64'h20);
    for (int i = 0; i < 3; i++) begin                 // c12..c14
      go(1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0, 32'h0);
      chk("slow_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h20});
      chk("slow_bubble", {63'h0, ifid_valid}, 64'h0);
    end
    go(1'b0, 1'b0, 1'b0, 32'h0);                      // c15
    chk("slow_done", {31'h0, ifid_valid, ifid_pc}, {31'h0, 1'b1, 32'h24});

    // Redirect to 0x100 while 0x24 is outstanding
    exp_req_q.push_back(32'h24); exp_req_q.push_back(32'h100);
    exp_ifid_q.push_back(tup(32'h100));
    go(1'b0, 1'b1, 1'b0, 32'h100);                    // c16
    go(1'b0, 1'b0, 1'b0, 32'h0);                      // c17
    chk("drain_flush", {31'h0, ifid_valid, ifid_pc}, 64'h0);
    chk("drain_flush_instr", {32'h0, ifid_instr}, 64'h0);
    chk("drain_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h24});
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c18
    chk("drain_ack_addr", {32'h0, imem_addr}, 64'h24);
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c19
    chk("target_addr", {32'h0, imem_addr}, 64'h100);
    chk("drain_dropped", {63'h0, ifid_valid}, 64'h0);

    // Branch together with freeze while in HOLD
    exp_req_q.push_back(32'h104); exp_req_q.push_back(32'h200);
    exp_ifid_q.push_back(tup(32'h200));
    go(1'b1, 1'b0, 1'b1, 32'h0);                      // c20
    chk("target_ifid", {ifid_instr, ifid_pc}, tup(32'h100));
    go(1'b1, 1'b1, 1'b1, 32'h200);                    // c21
    chk("hold2_req", {63'h0, imem_req}, 64'h0);
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c22
    chk("hold_branch_flush", {63'h0, ifid_valid}, 64'h0);
    chk("hold_branch_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h200});

    // Branch together with ack: no drain
    exp_req_q.push_back(32'h204); exp_req_q.push_back(32'h300);
    exp_ifid_q.push_back(tup(32'h300));
    go(1'b0, 1'b1, 1'b1, 32'h300);                    // c23
    go(1'b0, 1'b0, 1'b1, 32'h0);                      // c24
    chk("br_ack_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h300});
    chk("br_ack_flush", {63'h0, ifid_valid}, 64'h0);

    // Reset asserted in the middle of a drain
    go(1'b0, 1'b0, 1'b0, 32'h0);                      // c25
    go(1'b0, 1'b1, 1'b0, 32'h400);                    // c26
    go(1'b0, 1'b0, 1'b0, 32'h0);                      // c27
    chk("drain2_addr", {32'h0, imem_addr}, 64'h304);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {63'h0, imem_req}, 64'h0);
    chk("midrst_ifid", {ifid_instr, ifid_pc}, 64'h0);
    chk("midrst_valid", {63'h0, ifid_valid}, 64'h0);
    chk("midrst_addr", {32'h0, imem_addr}, 64'h0);
    exp_req_q.push_back(32'h0);
    exp_ifid_q.push_back(tup(32'h0));
    @(posedge clk); #1;
    rst_n = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    chk("rerun_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    go(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rerun_ifid", {31'h0, ifid_valid, ifid_pc}, {31'h0, 1'b1, 32'h4});

    chk("req_q_empty", 64'(exp_req_q.size()), 64'h0);
    chk("ifid_q_empty", 64'(exp_ifid_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
